// File: rtl/matrix_op_executor.sv
// matrix_op_executor: reads operand slots from the matrix BRAM, runs
// ADD / SCALAR_MUL / TRANSPOSE / CONV and streams the result into slot 0.
package matrix_op_selector_pkg;
  typedef enum logic [2:0] {
    CALC_ADD        = 3'd0,
    CALC_SCALAR_MUL = 3'd1,
    CALC_TRANSPOSE  = 3'd2,
    CALC_CONV       = 3'd3
  } calc_type_t;
endpackage

module matrix_op_executor
  import matrix_op_selector_pkg::*;
#(
  parameter int BLOCK_SIZE = 1152,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op_type,
  input  logic [2:0]            matrix_a,
  input  logic [2:0]            matrix_b,
  input  logic [31:0]           scalar_in,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_read_addr,
  input  logic [DATA_WIDTH-1:0] bram_data_out,
  output logic                  write_request,
  input  logic                  write_ready,
  output logic [2:0]            write_matrix_id,
  output logic [7:0]            write_rows,
  output logic [7:0]            write_cols,
  output logic [63:0]           write_name,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_data_valid,
  input  logic                  write_done,
  input  logic                  writer_ready,
  output logic [31:0]           cycle_count
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_DIM,
    S_CHECK,
    S_LOAD_K,
    S_WR_REQ,
    S_WAIT_READY,
    S_STREAM,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  // Per-element sub-phases while streaming
  localparam logic [1:0] P_RDA  = 2'd0;
  localparam logic [1:0] P_RDB  = 2'd1;
  localparam logic [1:0] P_CALC = 2'd2;
  localparam logic [1:0] P_OUT  = 2'd3;

  // "ANS" left-justified, zero padded; byte 0 in bits [63:56]
  localparam logic [63:0] ANS_NAME = 64'h414E530000000000;

  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [1:0] ku_q, ku_d, kv_q, kv_d;
  logic [1:0] ph_q, ph_d;
  logic [7:0] r_q, r_d, c_q, c_d;
  logic [7:0] rows_a_q, rows_a_d, cols_a_q, cols_a_d;
  logic [7:0] rows_b_q, rows_b_d, cols_b_q, cols_b_d;
  logic [7:0] out_rows_q, out_rows_d, out_cols_q, out_cols_d;
  logic [2:0] op_q, op_d, a_id_q, a_id_d, b_id_q, b_id_d;
  logic [31:0] scalar_q, scalar_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, res_q, res_d;
  logic [DATA_WIDTH-1:0] k_q [9];
  logic [DATA_WIDTH-1:0] k_d [9];
  logic [31:0] cnt_q, cnt_d;

  logic                  is_conv;
  logic [1:0]            first_ph;
  logic [ADDR_WIDTH-1:0] base_a, base_b, elem_off;
  logic [DATA_WIDTH-1:0] pix;

  assign is_conv  = (op_q == CALC_CONV);
  assign first_ph = is_conv ? P_CALC : P_RDA;
  assign base_a   = ADDR_WIDTH'(32'(a_id_q) * BLOCK_SIZE);
  assign base_b   = ADDR_WIDTH'(32'(b_id_q) * BLOCK_SIZE);
  assign elem_off = (op_q == CALC_TRANSPOSE)
    ? ADDR_WIDTH'(32'(c_q) * 32'(cols_a_q) + 32'(r_q))
    : ADDR_WIDTH'(32'(r_q) * 32'(cols_a_q) + 32'(c_q));
  assign pix = DATA_WIDTH'((32'(r_q) + 32'(ku_q)) * 32'd6
             + 32'(c_q) + 32'(kv_q) + 32'd1);

  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign write_request    = (state_q == S_WR_REQ) ||
                            (state_q == S_WAIT_READY) ||
                            (state_q == S_STREAM) ||
                            (state_q == S_WAIT_DONE);
  assign write_matrix_id  = 3'd0;
  assign write_rows       = out_rows_q;
  assign write_cols       = out_cols_q;
  assign write_name       = write_request ? ANS_NAME : 64'd0;
  assign write_data       = res_q;
  assign write_data_valid = (state_q == S_STREAM) &&
                            (ph_q == P_OUT) && writer_ready;
  assign cycle_count      = cnt_q;

  // BRAM read address for the current state / sub-step
  always_comb begin
    bram_read_addr = '0;
    case (state_q)
      S_RD_DIM: begin
        case (idx_q)
          4'd0:    bram_read_addr = base_a;
          4'd1:    bram_read_addr = base_a + ADDR_WIDTH'(1);
          4'd2:    bram_read_addr = base_b;
          4'd3:    bram_read_addr = base_b + ADDR_WIDTH'(1);
          default: bram_read_addr = '0;
        endcase
      end
      S_LOAD_K:
        bram_read_addr = base_a + ADDR_WIDTH'(4) + ADDR_WIDTH'(idx_q);
      S_STREAM: begin
        if (ph_q == P_RDA)
          bram_read_addr = base_a + ADDR_WIDTH'(4) + elem_off;
        else if (ph_q == P_RDB)
          bram_read_addr = base_b + ADDR_WIDTH'(4) + elem_off;
      end
      default: bram_read_addr = '0;
    endcase
  end

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ku_d       = ku_q;
    kv_d       = kv_q;
    ph_d       = ph_q;
    r_d        = r_q;
    c_d        = c_q;
    rows_a_d   = rows_a_q;
    cols_a_d   = cols_a_q;
    rows_b_d   = rows_b_q;
    cols_b_d   = cols_b_q;
    out_rows_d = out_rows_q;
    out_cols_d = out_cols_q;
    op_d       = op_q;
    a_id_d     = a_id_q;
    b_id_d     = b_id_q;
    scalar_d   = scalar_q;
    a_d        = a_q;
    res_d      = res_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = op_type;
          a_id_d   = matrix_a;
          b_id_d   = matrix_b;
          scalar_d = scalar_in;
          cnt_d    = '0;
          idx_d    = '0;
          state_d  = S_RD_DIM;
        end
      end
      S_RD_DIM: begin
        idx_d = idx_q + 4'd1;
        case (idx_q)
          4'd1: rows_a_d = bram_data_out[7:0];
          4'd2: cols_a_d = bram_data_out[7:0];
          4'd3: rows_b_d = bram_data_out[7:0];
          4'd4: begin
            cols_b_d = bram_data_out[7:0];
            state_d  = S_CHECK;
          end
          default: ;
        endcase
      end
      S_CHECK: begin
        idx_d      = '0;
        out_rows_d = rows_a_q;
        out_cols_d = cols_a_q;
        state_d    = S_DONE;
        if (rows_a_q != 8'd0 && cols_a_q != 8'd0) begin
          case (op_q)
            CALC_ADD:
              if (rows_a_q == rows_b_q && cols_a_q == cols_b_q)
                state_d = S_WR_REQ;
            CALC_SCALAR_MUL:
              state_d = S_WR_REQ;
            CALC_TRANSPOSE: begin
              out_rows_d = cols_a_q;
              out_cols_d = rows_a_q;
              state_d    = S_WR_REQ;
            end
            CALC_CONV: begin
              out_rows_d = 8'd4;
              out_cols_d = 8'd4;
              if (rows_a_q == 8'd3 && cols_a_q == 8'd3)
                state_d = S_LOAD_K;
            end
            default: state_d = S_DONE;
          endcase
        end
      end
      S_LOAD_K: begin
        idx_d = idx_q + 4'd1;
        if (idx_q != 4'd0)
          k_d[idx_q - 4'd1] = bram_data_out;
        if (idx_q == 4'd9)
          state_d = S_WR_REQ;
      end
      S_WR_REQ: state_d = S_WAIT_READY;
      S_WAIT_READY: begin
        if (write_ready) begin
          state_d = S_STREAM;
          r_d     = '0;
          c_d     = '0;
          idx_d   = '0;
          ku_d    = '0;
          kv_d    = '0;
          res_d   = '0;
          ph_d    = first_ph;
        end
      end
      S_STREAM: begin
        unique case (ph_q)
          P_RDA: ph_d = P_RDB;
          P_RDB: begin
            a_d  = bram_data_out;
            ph_d = P_CALC;
          end
          P_CALC: begin
            if (is_conv) begin
              res_d = res_q + k_q[idx_q] * pix;
              idx_d = idx_q + 4'd1;
              if (kv_q == 2'd2) begin
                kv_d = '0;
                ku_d = ku_q + 2'd1;
              end else begin
                kv_d = kv_q + 2'd1;
              end
              if (idx_q == 4'd8)
                ph_d = P_OUT;
            end else begin
              case (op_q)
                CALC_ADD:
                  res_d = a_q + bram_data_out;
                CALC_SCALAR_MUL:
                  res_d = a_q * DATA_WIDTH'(scalar_q);
                default:
                  res_d = a_q;
              endcase
              ph_d = P_OUT;
            end
          end
          P_OUT: begin
            if (writer_ready) begin
              ph_d  = first_ph;
              idx_d = '0;
              ku_d  = '0;
              kv_d  = '0;
              if (is_conv)
                res_d = '0;
              if (c_q == out_cols_q - 8'd1) begin
                c_d = '0;
                if (r_q == out_rows_q - 8'd1)
                  state_d = S_WAIT_DONE;
                else
                  r_d = r_q + 8'd1;
              end else begin
                c_d = c_q + 8'd1;
              end
            end
          end
        endcase
      end
      S_WAIT_DONE: if (write_done) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && state_q != S_DONE)
      cnt_d = cnt_q + 32'd1;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      ku_q       <= '0;
      kv_q       <= '0;
      ph_q       <= '0;
      r_q        <= '0;
      c_q        <= '0;
      rows_a_q   <= '0;
      cols_a_q   <= '0;
      rows_b_q   <= '0;
      cols_b_q   <= '0;
      out_rows_q <= '0;
      out_cols_q <= '0;
      op_q       <= '0;
      a_id_q     <= '0;
      b_id_q     <= '0;
      scalar_q   <= '0;
      a_q        <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < 9; i++)
        k_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ku_q       <= ku_d;
      kv_q       <= kv_d;
      ph_q       <= ph_d;
      r_q        <= r_d;
      c_q        <= c_d;
      rows_a_q   <= rows_a_d;
      cols_a_q   <= cols_a_d;
      rows_b_q   <= rows_b_d;
      cols_b_q   <= cols_b_d;
      out_rows_q <= out_rows_d;
      out_cols_q <= out_cols_d;
      op_q       <= op_d;
      a_id_q     <= a_id_d;
      b_id_q     <= b_id_d;
      scalar_q   <= scalar_d;
      a_q        <= a_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
    end
  end

endmodule

// File: tb/tb_matrix_op_executor.sv
// tb_matrix_op_executor: directed + random ops against a behavioural
// model of the matrix operations, with BRAM and storage-manager models.
module tb_matrix_op_executor;
  import matrix_op_selector_pkg::*;

  localparam int BS = 1152;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op_type, matrix_a, matrix_b;
  logic [31:0] scalar_in;
  logic        busy, done;
  logic [13:0] bram_read_addr;
  logic [31:0] bram_data_out;
  logic        write_request;
  logic        write_ready = 1'b0;
  logic [2:0]  write_matrix_id;
  logic [7:0]  write_rows, write_cols;
  logic [63:0] write_name;
  logic [31:0] write_data;
  logic        write_data_valid;
  logic        write_done = 1'b0;
  logic        writer_ready = 1'b0;
  logic [31:0] cycle_count;

  matrix_op_executor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_type(op_type),
    .matrix_a(matrix_a), .matrix_b(matrix_b), .scalar_in(scalar_in),
    .busy(busy), .done(done), .bram_read_addr(bram_read_addr),
    .bram_data_out(bram_data_out), .write_request(write_request),
    .write_ready(write_ready), .write_matrix_id(write_matrix_id),
    .write_rows(write_rows), .write_cols(write_cols),
    .write_name(write_name), .write_data(write_data),
    .write_data_valid(write_data_valid), .write_done(write_done),
    .writer_ready(writer_ready), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:16383];
  always @(posedge clk) bram_data_out <= mem[bram_read_addr];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] got[$];
  logic [31:0] exp_q[$];
  int          er, ec;
  bit          req_seen = 0;
  bit          hold_low = 0;
  bit          rand_ready = 0;
  int          cap_n = 0;
  logic [7:0]  cap_rows, cap_cols;
  logic [63:0] cap_name;
  logic [31:0] last_cc;

  // Storage manager responder: inputs change just after the clock edge
  always @(posedge clk) begin
    #1;
    write_ready  = write_request;
    writer_ready = hold_low ? 1'b0 :
                   (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    write_done   = write_request && req_seen && (got.size() == cap_n);
  end

  // Storage manager capture, sampled mid-cycle
  always @(negedge clk) begin
    if (write_data_valid) got.push_back(write_data);
    if (write_request && !req_seen) begin
      req_seen = 1;
      cap_rows = write_rows;
      cap_cols = write_cols;
      cap_name = write_name;
      cap_n    = int'(write_rows) * int'(write_cols);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_seq(input int slot, input int r, input int c,
                          input int v0);
    int b;
    b = slot * BS;
    mem[b] = 32'(r); mem[b+1] = 32'(c); mem[b+2] = 0; mem[b+3] = 0;
    for (int i = 0; i < r * c; i++) mem[b+4+i] = 32'(v0 + i);
  endtask

  task automatic fill_rand(input int slot, input int r, input int c);
    int b;
    b = slot * BS;
    mem[b] = 32'(r); mem[b+1] = 32'(c); mem[b+2] = 0; mem[b+3] = 0;
    for (int i = 0; i < r * c; i++) mem[b+4+i] = $urandom;
  endtask

  // Reference: compute expected result straight from the slot contents
  task automatic model(input logic [2:0] op, input int a, input int b,
                       input logic [31:0] s, output bit ok);
    int ba, bb, ra, ca, rb, cb;
    logic [31:0] acc;
    ba = a * BS; bb = b * BS;
    ra = int'(mem[ba]); ca = int'(mem[ba+1]);
    rb = int'(mem[bb]); cb = int'(mem[bb+1]);
    exp_q.delete(); ok = 1; er = 0; ec = 0;
    if (ra == 0 || ca == 0) ok = 0;
    else case (op)
      CALC_ADD:
        if (ra != rb || ca != cb) ok = 0;
        else begin
          er = ra; ec = ca;
          for (int i = 0; i < ra * ca; i++)
            exp_q.push_back(mem[ba+4+i] + mem[bb+4+i]);
        end
      CALC_SCALAR_MUL: begin
        er = ra; ec = ca;
        for (int i = 0; i < ra * ca; i++)
          exp_q.push_back(mem[ba+4+i] * s);
      end
      CALC_TRANSPOSE: begin
        er = ca; ec = ra;
        for (int r = 0; r < ca; r++)
          for (int c = 0; c < ra; c++)
            exp_q.push_back(mem[ba+4+c*ca+r]);
      end
      CALC_CONV:
        if (ra != 3 || ca != 3) ok = 0;
        else begin
          er = 4; ec = 4;
          for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
              acc = 0;
              for (int u = 0; u < 3; u++)
                for (int v = 0; v < 3; v++)
                  acc += mem[ba+4+u*3+v] * 32'((i+u)*6 + (j+v) + 1);
              exp_q.push_back(acc);
            end
        end
      default: ok = 0;
    endcase
  endtask

  task automatic run_op(input logic [2:0] op, input int a, input int b,
                        input logic [31:0] s, input bit poke,
                        input bit hold);
    bit ok;
    int t, n0, n;
    logic [31:0] d0;
    model(op, a, b, s, ok);
    got.delete(); req_seen = 0;
    @(negedge clk);
    op_type = op; matrix_a = 3'(a); matrix_b = 3'(b);
    scalar_in = s; start = 1;
    @(negedge clk);
    start = 0; op_type = 3'($urandom); matrix_a = 3'($urandom);
    matrix_b = 3'($urandom); scalar_in = $urandom;
    if (poke) begin
      repeat (3) @(negedge clk);
      op_type = CALC_TRANSPOSE; start = 1;
      @(negedge clk);
      start = 0;
    end
    if (hold) begin
      t = 0;
      while (got.size() < 2 && t < 3000) begin @(negedge clk); t++; end
      hold_low = 1;
      repeat (15) @(negedge clk);
      n0 = got.size(); d0 = write_data;
      repeat (10) @(negedge clk);
      chk("hold_no_strobe", 64'(got.size()), 64'(n0));
      chk("hold_data", write_data, d0);
      hold_low = 0;
    end
    t = 0;
    while (done !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
    chk("done_seen", done, 1'b1);
    last_cc = cycle_count;
    @(negedge clk);
    chk("done_pulse_busy", {done, busy}, 2'b00);
    repeat (3) @(negedge clk);
    chk("cc_stable", cycle_count, last_cc);
    chk("req_seen", req_seen, ok);
    if (ok) begin
      chk("count", 64'(got.size()), 64'(exp_q.size()));
      chk("rows", cap_rows, 8'(er));
      chk("cols", cap_cols, 8'(ec));
      chk("name", cap_name, 64'h414E530000000000);
      n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      for (int i = 0; i < n; i++)
        chk($sformatf("elem%0d", i), got[i], exp_q[i]);
    end
  endtask

  initial begin
    int t;
    for (int i = 0; i < 16384; i++) mem[i] = 0;
    rst_n = 0; start = 0; op_type = 0; matrix_a = 0; matrix_b = 0;
    scalar_in = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy_done", {busy, done}, 2'b00);
    chk("rst_write", {write_request, write_data_valid}, 2'b00);
    chk("rst_addr", bram_read_addr, 14'd0);
    chk("rst_data", write_data, 32'd0);
    chk("rst_dims", {write_rows, write_cols, write_matrix_id}, 19'd0);
    chk("rst_name", write_name, 64'd0);
    chk("rst_cc", cycle_count, 32'd0);
    rst_n = 1;

    fill_seq(1, 2, 2, 1);
    fill_seq(2, 2, 2, 5);
    fill_seq(3, 3, 3, 1);
    fill_seq(4, 2, 3, 1);
    fill_rand(5, 3, 3);

    run_op(CALC_SCALAR_MUL, 1, 0, 32'd10, 0, 0);
    chk("mul_last", got[3], 32'd40);
    run_op(CALC_ADD, 1, 2, 32'd0, 1, 0);
    chk("add_first", got[0], 32'd6);
    run_op(CALC_TRANSPOSE, 1, 0, 32'd0, 0, 0);
    run_op(CALC_TRANSPOSE, 4, 0, 32'd0, 0, 0);
    chk("tr23_second", got[1], 32'd4);
    run_op(CALC_CONV, 3, 0, 32'd0, 0, 1);
    chk("conv_00", got[0], 32'd474);
    chk("conv_cc_pos", last_cc != 0, 1'b1);
    run_op(CALC_ADD, 1, 5, 32'd0, 0, 0);
    run_op(CALC_CONV, 1, 0, 32'd0, 0, 0);
    run_op(3'd7, 1, 2, 32'd0, 0, 0);

    rand_ready = 1;
    for (int it = 0; it < 8; it++) begin
      int op, r, c;
      op = $urandom_range(0, 3);
      r = $urandom_range(1, 4);
      c = $urandom_range(1, 4);
      fill_rand(6, r, c);
      fill_rand(7, r, c);
      fill_rand(5, 3, 3);
      run_op(3'(op), (op == 3) ? 5 : 6, 7, $urandom, 0, 0);
    end
    rand_ready = 0;

    got.delete(); req_seen = 0;
    @(negedge clk);
    op_type = CALC_CONV; matrix_a = 3'd5; start = 1;
    @(negedge clk);
    start = 0;
    t = 0;
    while (got.size() < 3 && t < 2000) begin @(negedge clk); t++; end
    chk("midrst_reach", got.size() >= 3, 1'b1);
    rst_n = 0;
    #1;
    chk("midrst_req", write_request, 1'b0);
    chk("midrst_busy", {busy, write_data_valid}, 2'b00);
    chk("midrst_regs", {bram_read_addr, cycle_count}, 46'd0);
    @(negedge clk);
    rst_n = 1;
    run_op(CALC_SCALAR_MUL, 1, 0, 32'hFFFF_FFFD, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
